// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the two caches and main memory.
// The slave modport is the arbiter's view; master is the view of the caches/memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3
);
  logic [1:0]                  i_cache_mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       i_cache_mem_vis_addr;
  logic [1:0]                  i_cache_status;
  logic [1:0]                  d_cache_mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr;
  logic [DATA_LEN-1:0]         d_cache_written_data;
  logic [2:0]                  d_cache_data_type;
  logic [ENTRY_INDEX_SIZE:0]   d_cache_write_length;
  logic [1:0]                  d_cache_status;
  logic [DATA_LEN-1:0]         arb_read_data;
  logic [1:0]                  mem_vis_signal;
  logic [ADDR_WIDTH-1:0]       mem_vis_addr;
  logic [DATA_LEN-1:0]         mem_written_data;
  logic [2:0]                  mem_data_type;
  logic [ENTRY_INDEX_SIZE:0]   mem_write_length;
  logic [DATA_LEN-1:0]         mem_data;
  logic [1:0]                  mem_status;

  modport slave (
    input  i_cache_mem_vis_signal, i_cache_mem_vis_addr,
    input  d_cache_mem_vis_signal, d_cache_mem_vis_addr, d_cache_written_data,
    input  d_cache_data_type, d_cache_write_length,
    input  mem_data, mem_status,
    output i_cache_status, d_cache_status, arb_read_data,
    output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_write_length
  );

  modport master (
    output i_cache_mem_vis_signal, i_cache_mem_vis_addr,
    output d_cache_mem_vis_signal, d_cache_mem_vis_addr, d_cache_written_data,
    output d_cache_data_type, d_cache_write_length,
    output mem_data, mem_status,
    input  i_cache_status, d_cache_status, arb_read_data,
    input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_write_length
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single main-memory port between the I-cache and D-cache.
// Defining MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that ends a stuck access with status 11.
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus_io
);
  localparam int LEN_W = ENTRY_INDEX_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e     state_q;
  logic       ownerD_q;
  logic       lastOwnerD_q;
  logic       iValid;
  logic       dValid;
  logic       grantAny;
  logic       grantToD;
  logic [1:0] iStatus;
  logic [1:0] dStatus;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WD_W-1:0] wdCount_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

  assign iValid   = (bus_io.i_cache_mem_vis_signal == 2'b01);
  assign dValid   = (bus_io.d_cache_mem_vis_signal == 2'b01) ||
                    (bus_io.d_cache_mem_vis_signal == 2'b10);
  assign grantAny = iValid || dValid;
  // On a tie the requester that was not served last wins; last owner resets to I so D wins first.
  assign grantToD = dValid && (!iValid || !lastOwnerD_q);

  always_comb begin
    iStatus = iValid ? 2'b01 : 2'b00;
    dStatus = dValid ? 2'b01 : 2'b00;
    if (state_q == RESP) begin
      if (ownerD_q) dStatus = 2'b10;
      else          iStatus = 2'b10;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    if (state_q == ERR) begin
      if (ownerD_q) dStatus = 2'b11;
      else          iStatus = 2'b11;
    end
`endif
  end

  assign bus_io.i_cache_status = iStatus;
  assign bus_io.d_cache_status = dStatus;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                 <= IDLE;
      ownerD_q                <= 1'b0;
      lastOwnerD_q            <= 1'b0;
      bus_io.mem_vis_signal   <= 2'b00;
      bus_io.mem_vis_addr     <= '0;
      bus_io.mem_written_data <= '0;
      bus_io.mem_data_type    <= 3'b000;
      bus_io.mem_write_length <= '0;
      bus_io.arb_read_data    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wdCount_q               <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grantAny) begin
            ownerD_q <= grantToD;
            state_q  <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            wdCount_q <= '0;
`endif
            if (grantToD) begin
              bus_io.mem_vis_signal   <= bus_io.d_cache_mem_vis_signal;
              bus_io.mem_vis_addr     <= bus_io.d_cache_mem_vis_addr;
              bus_io.mem_written_data <= bus_io.d_cache_written_data;
              bus_io.mem_data_type    <= bus_io.d_cache_data_type;
              bus_io.mem_write_length <= bus_io.d_cache_write_length;
            end else begin
              bus_io.mem_vis_signal   <= 2'b01;
              bus_io.mem_vis_addr     <= bus_io.i_cache_mem_vis_addr;
              bus_io.mem_written_data <= '0;
              bus_io.mem_data_type    <= 3'b010;
              bus_io.mem_write_length <= LEN_W'(1);
            end
          end
        end
        BUSY: begin
          // The command stays frozen here; requester inputs are not looked at until IDLE.
          if (bus_io.mem_status == 2'b10) begin
            if (bus_io.mem_vis_signal == 2'b01) bus_io.arb_read_data <= bus_io.mem_data;
            bus_io.mem_vis_signal <= 2'b00;
            lastOwnerD_q          <= ownerD_q;
            state_q               <= RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wdCount_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            bus_io.mem_vis_signal <= 2'b00;
            lastOwnerD_q          <= ownerD_q;
            state_q               <= ERR;
          end else begin
            wdCount_q <= wdCount_q + WD_W'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, scoreboard-based bench for mem_arbiter with a simple latency-programmable memory model.
// Build with MEM_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_mem_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int EIS = 3;
  localparam int LW  = EIS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .ENTRY_INDEX_SIZE(EIS)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_LEN(DW), .ENTRY_INDEX_SIZE(EIS), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  typedef struct {
    bit          isD;
    logic [1:0]  sig;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]  typ;
    logic [LW-1:0] len;
  } txn_t;

  txn_t          expQ[$];
  txn_t          cur;
  int            nChecks = 0;
  int            nPass   = 0;
  logic [1:0]    iSigDrv = 2'b00;
  logic [1:0]    dSigDrv = 2'b00;
  logic [DW-1:0] modelArb = '0;
  logic [DW-1:0] memWord  = '0;
  int            memLatency = 1;
  bit            memHang = 1'b0;
  int            busyCnt = 0;

  // Memory answers done once the command has been visible for memLatency cycles.
  always @(posedge clk) begin
    #1;
    if (bus.mem_vis_signal != 2'b00) begin
      busyCnt++;
      if (!memHang && busyCnt >= memLatency) begin
        bus.mem_status = 2'b10;
        bus.mem_data   = memWord;
      end else begin
        bus.mem_status = 2'b01;
        bus.mem_data   = ~memWord;
      end
    end else begin
      busyCnt        = 0;
      bus.mem_status = 2'b00;
      bus.mem_data   = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [1:0] expStatus(input bit isD);
    if (isD) return (dSigDrv == 2'b01 || dSigDrv == 2'b10) ? 2'b01 : 2'b00;
    return (iSigDrv == 2'b01) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [1:0] dutStatus(input bit isD);
    return isD ? bus.d_cache_status : bus.i_cache_status;
  endfunction

  task automatic applyStimulus(input bit isD, input logic [1:0] sig, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [2:0] typ, input logic [LW-1:0] len);
    txn_t t;
    t.isD  = isD;
    t.sig  = isD ? sig : 2'b01;
    t.addr = addr;
    if (isD) begin
      bus.d_cache_mem_vis_signal = sig;
      bus.d_cache_mem_vis_addr   = addr;
      bus.d_cache_written_data   = data;
      bus.d_cache_data_type      = typ;
      bus.d_cache_write_length   = len;
      dSigDrv = sig;
      t.data = data;
      t.typ  = typ;
      t.len  = len;
    end else begin
      bus.i_cache_mem_vis_signal = sig;
      bus.i_cache_mem_vis_addr   = addr;
      iSigDrv = sig;
      t.data = '0;
      t.typ  = 3'b010;
      t.len  = LW'(1);
    end
    if (expStatus(isD) == 2'b01) expQ.push_back(t);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);
    repeat (2) @(negedge clk);
    expQ.delete();
    modelArb = '0;
    rst = 1'b0;
  endtask

  task automatic expectGrant(input int expDelay);
    int n = 0;
    while (bus.mem_vis_signal == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("grantSeen", 64'(bus.mem_vis_signal != 2'b00), 64'd1);
    if (bus.mem_vis_signal == 2'b00) return;
    if (expDelay >= 0) checkOutput("grantDelay", 64'(n), 64'(expDelay));
    if (expQ.size() == 0) begin
      checkOutput("unexpectedGrant", 64'(bus.mem_vis_signal), 64'd0);
      return;
    end
    cur = expQ.pop_front();
    checkOutput("memSignal", 64'(bus.mem_vis_signal), 64'(cur.sig));
    checkOutput("memAddr", 64'(bus.mem_vis_addr), 64'(cur.addr));
    checkOutput("memWData", 64'(bus.mem_written_data), 64'(cur.data));
    checkOutput("memType", 64'(bus.mem_data_type), 64'(cur.typ));
    checkOutput("memLen", 64'(bus.mem_write_length), 64'(cur.len));
    checkOutput("otherStatusBusy", 64'(dutStatus(!cur.isD)), 64'(expStatus(!cur.isD)));
  endtask

  task automatic expectResp(input int expBusy, input logic [1:0] expCode);
    int n = 0;
    logic [1:0] st;
    st = dutStatus(cur.isD);
    while (!st[1] && n < 60) begin
      checkOutput("heldAddr", 64'(bus.mem_vis_addr), 64'(cur.addr));
      checkOutput("heldSignal", 64'(bus.mem_vis_signal), 64'(cur.sig));
      @(negedge clk);
      n++;
      st = dutStatus(cur.isD);
    end
    checkOutput("respCode", 64'(st), 64'(expCode));
    if (expBusy >= 0) checkOutput("busyCycles", 64'(n), 64'(expBusy));
    checkOutput("respSignalIdle", 64'(bus.mem_vis_signal), 64'd0);
    if (expCode == 2'b10 && cur.sig == 2'b01) modelArb = memWord;
    checkOutput("readData", 64'(bus.arb_read_data), 64'(modelArb));
    checkOutput("otherStatusResp", 64'(dutStatus(!cur.isD)), 64'(expStatus(!cur.isD)));
  endtask

  task automatic expectIdleAfter();
    @(negedge clk);
    checkOutput("pulseEnd", 64'(dutStatus(cur.isD)), 64'(expStatus(cur.isD)));
    checkOutput("idleSignal", 64'(bus.mem_vis_signal), 64'd0);
    checkOutput("readDataHold", 64'(bus.arb_read_data), 64'(modelArb));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global time limit expired");
  end

  initial begin
    // Reset values
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);
    repeat (2) @(negedge clk);
    checkOutput("rstSignal", 64'(bus.mem_vis_signal), 64'd0);
    checkOutput("rstAddr", 64'(bus.mem_vis_addr), 64'd0);
    checkOutput("rstWData", 64'(bus.mem_written_data), 64'd0);
    checkOutput("rstType", 64'(bus.mem_data_type), 64'd0);
    checkOutput("rstLen", 64'(bus.mem_write_length), 64'd0);
    checkOutput("rstIStatus", 64'(bus.i_cache_status), 64'd0);
    checkOutput("rstDStatus", 64'(bus.d_cache_status), 64'd0);
    checkOutput("rstReadData", 64'(bus.arb_read_data), 64'd0);
    rst = 1'b0;

    // Reserved request codes behave as idle
    applyStimulus(1'b0, 2'b10, 17'h00100, '0, 3'b000, '0);
    applyStimulus(1'b1, 2'b11, 17'h00200, 32'h1, 3'b001, 4'd2);
    repeat (3) @(negedge clk);
    checkOutput("reservedSignal", 64'(bus.mem_vis_signal), 64'd0);
    checkOutput("reservedIStatus", 64'(bus.i_cache_status), 64'd0);
    checkOutput("reservedDStatus", 64'(bus.d_cache_status), 64'd0);
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);

    // I-cache read, three busy cycles
    memLatency = 3;
    memWord    = 32'hDEADBEEF;
    applyStimulus(1'b0, 2'b01, 17'h00010, '0, 3'b000, '0);
    expectGrant(1);
    expectResp(3, 2'b10);
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    expectIdleAfter();

    // D-cache write leaves the read word alone
    memLatency = 2;
    memWord    = 32'hCAFEF00D;
    applyStimulus(1'b1, 2'b10, 17'h1FFFC, 32'h12345678, 3'b010, 4'd4);
    expectGrant(1);
    expectResp(2, 2'b10);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);
    expectIdleAfter();

    // Simultaneous requests after reset: D first, then I after one idle cycle
    doReset();
    memLatency = 2;
    memWord    = 32'h11111111;
    applyStimulus(1'b1, 2'b01, 17'h00400, '0, 3'b100, 4'd1);
    applyStimulus(1'b0, 2'b01, 17'h00800, '0, 3'b000, '0);
    expectGrant(1);
    expectResp(2, 2'b10);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);
    memWord = 32'h22222222;
    expectGrant(2);
    expectResp(2, 2'b10);
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    expectIdleAfter();

    // Continuous contention: six grants alternate D,I,D,I,D,I
    doReset();
    applyStimulus(1'b1, 2'b01, 17'h00100, '0, 3'b010, 4'd1);
    applyStimulus(1'b0, 2'b01, 17'h00200, '0, 3'b000, '0);
    for (int k = 0; k < 6; k++) begin
      memLatency = 1 + (k % 3);
      memWord    = 32'hA0000000 + 32'(k);
      expectGrant(k == 0 ? 1 : 2);
      expectResp(memLatency, 2'b10);
      if (k < 4) begin
        if (cur.isD)
          applyStimulus(1'b1, (k == 2) ? 2'b10 : 2'b01, 17'h00100 + 17'(k), 32'h55550000 + 32'(k),
                        3'b010, 4'd3);
        else
          applyStimulus(1'b0, 2'b01, 17'h00200 + 17'(k), '0, 3'b000, '0);
      end else begin
        applyStimulus(cur.isD, 2'b00, '0, '0, 3'b000, '0);
      end
    end
    expectIdleAfter();

    // Request dropped while BUSY still completes
    memLatency = 4;
    memWord    = 32'h0BADCAFE;
    applyStimulus(1'b1, 2'b01, 17'h00ABC, '0, 3'b001, 4'd1);
    expectGrant(1);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);
    expectResp(4, 2'b10);
    expectIdleAfter();

    // Reset in the middle of a transaction
    memHang = 1'b1;
    applyStimulus(1'b0, 2'b01, 17'h00777, '0, 3'b000, '0);
    expectGrant(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstSignal", 64'(bus.mem_vis_signal), 64'd0);
    checkOutput("midRstReadData", 64'(bus.arb_read_data), 64'd0);
    checkOutput("midRstIStatus", 64'(bus.i_cache_status), 64'd1);
    rst      = 1'b0;
    modelArb = '0;
    memHang  = 1'b0;
    memLatency = 1;
    memWord  = 32'h77770001;
    expQ.delete();
    applyStimulus(1'b0, 2'b01, 17'h00777, '0, 3'b000, '0);
    expectGrant(1);
    expectResp(1, 2'b10);
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    expectIdleAfter();

    // Memory that never completes
    doReset();
    memHang = 1'b1;
    memWord = 32'h99999999;
    applyStimulus(1'b1, 2'b01, 17'h00F00, '0, 3'b010, 4'd1);
    expectGrant(1);
    applyStimulus(1'b0, 2'b01, 17'h00F10, '0, 3'b000, '0);
`ifdef MEM_ARB_TIMEOUT_EN
    expectResp(8, 2'b11);
    applyStimulus(1'b1, 2'b00, '0, '0, 3'b000, '0);
    expectIdleAfter();
    memHang    = 1'b0;
    memLatency = 2;
    memWord    = 32'h33334444;
    expectGrant(1);
    expectResp(2, 2'b10);
    applyStimulus(1'b0, 2'b00, '0, '0, 3'b000, '0);
    expectIdleAfter();
`else
    repeat (20) @(negedge clk);
    checkOutput("hangDStatus", 64'(bus.d_cache_status), 64'd1);
    checkOutput("hangSignal", 64'(bus.mem_vis_signal), 64'd1);
    checkOutput("hangAddr", 64'(bus.mem_vis_addr), 64'h00F00);
    checkOutput("hangIStatus", 64'(bus.i_cache_status), 64'd1);
    memHang = 1'b0;
    doReset();
`endif

    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
